// File: rtl/ariane_pkg.sv
// Slice of the CVA6 core package: scoreboard entry, exception and FU types
// shared between the issue, execute and commit stages.
package ariane_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned VLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, XORL, ORL, ANDL, SLTS, SLTU, SLL, SRL, SRA, LW, SW, MUL, CSR_RW
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    fu_op                     op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    logic                     use_imm;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/commit_feeder_pkg.sv
// Shared definitions for the commit queue feeder: entry flags, default sizing
// and the circular pointer helper.
package commit_feeder_pkg;

  localparam int unsigned DEF_NR_ENTRIES      = 8;
  localparam int unsigned DEF_NR_COMMIT_PORTS = 2;
  localparam int unsigned DEF_XLEN            = 32;

  typedef struct packed {
    logic allocated;
    logic finished;
  } entry_flags_t;

  // Depth is a power of two, so wrapping is a mask.
  function automatic int unsigned ptr_add(input int unsigned ptr,
                                          input int unsigned inc,
                                          input int unsigned depth);
    return (ptr + inc) & (depth - 1);
  endfunction

endpackage

// File: rtl/commit_feeder_ptr_ctrl.sv
// Head/tail/count bookkeeping for the retire queue: accepts issues, retires
// acknowledged entries and resets everything on flush.
module commit_feeder_ptr_ctrl
  import commit_feeder_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = DEF_NR_ENTRIES,
  parameter int unsigned NR_COMMIT_PORTS = DEF_NR_COMMIT_PORTS,
  parameter int unsigned TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0] ack_i,
  output logic                       push_o,
  output logic                       issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]   head_o,
  output logic [TRANS_ID_BITS-1:0]   tail_o,
  output logic [TRANS_ID_BITS:0]     count_o
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  logic [TRANS_ID_BITS-1:0] head_q, head_d;
  logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         pop;

  // ack_i is already a contiguous prefix from port 0, so its popcount is the pop amount.
  always_comb begin
    pop           = '0;
    issue_ready_o = 1'b0;
    push_o        = 1'b0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      pop = pop + CNT_W'(ack_i[k]);
    end

    issue_ready_o = (count_q < CNT_W'(NR_ENTRIES));
    push_o        = issue_valid_i & issue_ready_o & ~flush_i;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = TRANS_ID_BITS'(ptr_add(32'(head_q), 32'(pop), NR_ENTRIES));
      tail_d  = TRANS_ID_BITS'(ptr_add(32'(tail_q), 32'(push_o), NR_ENTRIES));
      count_d = count_q + CNT_W'(push_o) - pop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/commit_queue_feeder.sv
// In-order retire queue that feeds the commit stage: allocate at issue, mark
// finished on writeback, present oldest entries and pop on acknowledge.
module commit_queue_feeder
  import commit_feeder_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = DEF_NR_ENTRIES,
  parameter int unsigned NR_COMMIT_PORTS = DEF_NR_COMMIT_PORTS,
  parameter int unsigned TRANS_ID_BITS   = $clog2(NR_ENTRIES),
  parameter int unsigned XLEN            = DEF_XLEN
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic                                                   flush_i,
  input  logic                                                   issue_valid_i,
  input  ariane_pkg::scoreboard_entry_t                          issue_instr_i,
  output logic                                                   issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                               issue_trans_id_o,
  input  logic                                                   wb_valid_i,
  input  logic [TRANS_ID_BITS-1:0]                               wb_trans_id_i,
  input  logic [XLEN-1:0]                                        wb_result_i,
  input  ariane_pkg::exception_t                                 wb_ex_i,
  output ariane_pkg::scoreboard_entry_t [NR_COMMIT_PORTS-1:0]    commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                             commit_ack_i,
  output logic [TRANS_ID_BITS:0]                                 count_o
);

  localparam int unsigned CNT_W  = TRANS_ID_BITS + 1;
  localparam int unsigned SB_XLEN = ariane_pkg::XLEN;

  ariane_pkg::scoreboard_entry_t [NR_ENTRIES-1:0] entries_q, entries_d;
  entry_flags_t [NR_ENTRIES-1:0]                  flags_q, flags_d;

  logic [TRANS_ID_BITS-1:0]   head, tail;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [NR_COMMIT_PORTS-1:0] ack_ok;
  logic [TRANS_ID_BITS-1:0]   port_idx [NR_COMMIT_PORTS];

  commit_feeder_ptr_ctrl #(
    .NR_ENTRIES      (NR_ENTRIES),
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .TRANS_ID_BITS   (TRANS_ID_BITS)
  ) i_ptr_ctrl (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .ack_i         (ack_ok),
    .push_o        (push),
    .issue_ready_o (issue_ready_o),
    .head_o        (head),
    .tail_o        (tail),
    .count_o       (count)
  );

  // Presentation; an ack only counts on a valid port with every lower port also retiring.
  always_comb begin
    logic ok;
    ok     = 1'b1;
    ack_ok = '0;
    commit_valid = '0;
    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      port_idx[k]             = TRANS_ID_BITS'(ptr_add(32'(head), k, NR_ENTRIES));
      commit_valid[k]         = (CNT_W'(k) < count) && flags_q[port_idx[k]].finished;
      commit_instr_o[k]       = entries_q[port_idx[k]];
      commit_instr_o[k].valid = commit_valid[k];
      ok                      = ok & commit_ack_i[k] & commit_valid[k];
      ack_ok[k]               = ok;
    end
  end

  always_comb begin
    entries_d = entries_q;
    flags_d   = flags_q;
    if (flush_i) begin
      flags_d = '0;
    end else begin
      if (push) begin
        entries_d[tail]          = issue_instr_i;
        entries_d[tail].result   = '0;
        entries_d[tail].ex.valid = 1'b0;
        entries_d[tail].valid    = 1'b0;
        flags_d[tail]            = '{allocated: 1'b1, finished: 1'b0};
      end
      if (wb_valid_i && flags_q[wb_trans_id_i].allocated) begin
        entries_d[wb_trans_id_i].result = SB_XLEN'(wb_result_i);
        entries_d[wb_trans_id_i].ex     = wb_ex_i;
        flags_d[wb_trans_id_i].finished = 1'b1;
      end
      for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (ack_ok[k]) begin
          flags_d[port_idx[k]] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Payload carries no reset; the flags alone decide what is live.
  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
  end

  assign issue_trans_id_o = tail;
  assign count_o          = count;

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      if (wb_valid_i) begin
        assert (flags_q[wb_trans_id_i].allocated)
          else $error("writeback to unallocated entry %0d", wb_trans_id_i);
        assert (!flags_q[wb_trans_id_i].finished)
          else $warning("writeback overwrites finished entry %0d", wb_trans_id_i);
      end
      for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
        assert (!commit_ack_i[k] || commit_valid[k])
          else $warning("ack on port %0d with no valid entry ignored", k);
      end
    end
  end

  if (NR_COMMIT_PORTS > 1) begin : g_ack_order
    always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i) begin
        assert (!(commit_ack_i[1] && !commit_ack_i[0]))
          else $warning("ack on port 1 without port 0 ignored");
      end
    end
  end

endmodule

// File: tb/tb_commit_queue_feeder.sv
// Directed bench for commit_queue_feeder with hand-computed expectations.
module tb_commit_queue_feeder;
  import ariane_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i;
  logic                    issue_valid_i;
  scoreboard_entry_t       issue_instr_i;
  logic                    issue_ready_o;
  logic [2:0]              issue_trans_id_o;
  logic                    wb_valid_i;
  logic [2:0]              wb_trans_id_i;
  logic [31:0]             wb_result_i;
  exception_t              wb_ex_i;
  scoreboard_entry_t [1:0] commit_instr_o;
  logic [1:0]              commit_ack_i;
  logic [3:0]              count_o;

  int vectors    = 0;
  int miscompares = 0;

  commit_queue_feeder #(
    .NR_ENTRIES      (8),
    .NR_COMMIT_PORTS (2),
    .TRANS_ID_BITS   (3),
    .XLEN            (32)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_instr_i    (issue_instr_i),
    .issue_ready_o    (issue_ready_o),
    .issue_trans_id_o (issue_trans_id_o),
    .wb_valid_i       (wb_valid_i),
    .wb_trans_id_i    (wb_trans_id_i),
    .wb_result_i      (wb_result_i),
    .wb_ex_i          (wb_ex_i),
    .commit_instr_o   (commit_instr_o),
    .commit_ack_i     (commit_ack_i),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Result and ex.valid carry junk so the bench can see they are cleared on issue.
  function automatic scoreboard_entry_t mk(input logic [31:0] pc);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = pc;
    e.fu       = ALU;
    e.op       = ADD;
    e.rd       = pc[6:2];
    e.result   = 32'hDEAD_BEEF;
    e.valid    = 1'b1;
    e.ex.valid = 1'b1;
    return e;
  endfunction

  task automatic issue(input logic [31:0] pc);
    issue_valid_i = 1'b1;
    issue_instr_i = mk(pc);
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic wb(input logic [2:0] id, input logic [31:0] res);
    wb_valid_i    = 1'b1;
    wb_trans_id_i = id;
    wb_result_i   = res;
    tick();
    wb_valid_i    = 1'b0;
  endtask

  task automatic ack(input logic [1:0] a);
    commit_ack_i = a;
    tick();
    commit_ack_i = 2'b00;
  endtask

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    wb_valid_i    = 1'b0;
    wb_trans_id_i = '0;
    wb_result_i   = '0;
    wb_ex_i       = '0;
    commit_ack_i  = 2'b00;

    // Reset state
    tick();
    tick();
    check("rst_ready",  64'(issue_ready_o), 64'd1);
    check("rst_tid",    64'(issue_trans_id_o), 64'd0);
    check("rst_count",  64'(count_o), 64'd0);
    check("rst_valid0", 64'(commit_instr_o[0].valid), 64'd0);
    check("rst_valid1", 64'(commit_instr_o[1].valid), 64'd0);
    rst_ni = 1'b1;
    tick();
    check("idle_count", 64'(count_o), 64'd0);

    // Three issues, out-of-order writeback, dual retire
    check("tid_0", 64'(issue_trans_id_o), 64'd0);
    issue(32'h100);
    check("tid_1", 64'(issue_trans_id_o), 64'd1);
    issue(32'h104);
    issue(32'h108);
    check("cnt_3", 64'(count_o), 64'd3);
    check("tid_3", 64'(issue_trans_id_o), 64'd3);

    wb(3'd1, 32'hAA);
    check("p0_unfinished", 64'(commit_instr_o[0].valid), 64'd0);
    check("p1_finished",   64'(commit_instr_o[1].valid), 64'd1);

    wb_valid_i    = 1'b1;
    wb_trans_id_i = 3'd0;
    wb_result_i   = 32'hBB;
    check("no_bypass", 64'(commit_instr_o[0].valid), 64'd0);
    tick();
    wb_valid_i = 1'b0;
    check("p0_valid",  64'(commit_instr_o[0].valid), 64'd1);
    check("p0_pc",     64'(commit_instr_o[0].pc), 64'h100);
    check("p0_result", 64'(commit_instr_o[0].result), 64'hBB);
    check("p1_valid",  64'(commit_instr_o[1].valid), 64'd1);
    check("p1_pc",     64'(commit_instr_o[1].pc), 64'h104);
    check("p1_result", 64'(commit_instr_o[1].result), 64'hAA);

    ack(2'b11);
    check("pop2_cnt",      64'(count_o), 64'd1);
    check("pop2_p0_pc",    64'(commit_instr_o[0].pc), 64'h108);
    check("pop2_p0_valid", 64'(commit_instr_o[0].valid), 64'd0);
    check("pop2_p0_res",   64'(commit_instr_o[0].result), 64'd0);
    check("pop2_p0_exv",   64'(commit_instr_o[0].ex.valid), 64'd0);

    // Illegal acks leave state untouched
    ack(2'b01);
    check("ack_unfin_cnt", 64'(count_o), 64'd1);
    ack(2'b10);
    check("ack_p1only_cnt", 64'(count_o), 64'd1);
    wb(3'd2, 32'h77);
    check("e2_valid", 64'(commit_instr_o[0].valid), 64'd1);
    check("e2_res",   64'(commit_instr_o[0].result), 64'h77);
    ack(2'b10);
    check("ack_p1only_fin_cnt", 64'(count_o), 64'd1);
    check("ack_p1only_fin_v",   64'(commit_instr_o[0].valid), 64'd1);
    ack(2'b01);
    check("drain_cnt", 64'(count_o), 64'd0);
    check("drain_v0",  64'(commit_instr_o[0].valid), 64'd0);
    check("drain_tid", 64'(issue_trans_id_o), 64'd3);

    // Flush with 5 entries live, colliding with issue, writeback and ack
    for (int i = 0; i < 5; i++) issue(32'h400 + 32'(4 * i));
    check("pre_flush_cnt", 64'(count_o), 64'd5);
    check("pre_flush_tid", 64'(issue_trans_id_o), 64'd0);
    wb(3'd3, 32'h33);
    check("pre_flush_v0", 64'(commit_instr_o[0].valid), 64'd1);
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    issue_instr_i = mk(32'h500);
    wb_valid_i    = 1'b1;
    wb_trans_id_i = 3'd4;
    wb_result_i   = 32'h44;
    commit_ack_i  = 2'b01;
    tick();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    wb_valid_i    = 1'b0;
    commit_ack_i  = 2'b00;
    check("flush_cnt",   64'(count_o), 64'd0);
    check("flush_tid",   64'(issue_trans_id_o), 64'd0);
    check("flush_v0",    64'(commit_instr_o[0].valid), 64'd0);
    check("flush_v1",    64'(commit_instr_o[1].valid), 64'd0);
    check("flush_ready", 64'(issue_ready_o), 64'd1);

    // Fill, exception writeback, full-queue issue rejection while popping, wrap
    for (int i = 0; i < 8; i++) issue(32'h200 + 32'(4 * i));
    check("full_cnt",   64'(count_o), 64'd8);
    check("full_ready", 64'(issue_ready_o), 64'd0);
    check("full_tid",   64'(issue_trans_id_o), 64'd0);

    wb_ex_i       = '0;
    wb_ex_i.valid = 1'b1;
    wb_ex_i.cause = 32'd2;
    wb(3'd0, 32'h55);
    wb_ex_i = '0;
    check("ex_v0",    64'(commit_instr_o[0].valid), 64'd1);
    check("ex_pc",    64'(commit_instr_o[0].pc), 64'h200);
    check("ex_valid", 64'(commit_instr_o[0].ex.valid), 64'd1);
    check("ex_cause", 64'(commit_instr_o[0].ex.cause), 64'd2);
    check("ex_v1",    64'(commit_instr_o[1].valid), 64'd0);

    issue_valid_i = 1'b1;
    issue_instr_i = mk(32'h300);
    commit_ack_i  = 2'b01;
    check("full_pop_ready", 64'(issue_ready_o), 64'd0);
    tick();
    commit_ack_i = 2'b00;
    check("rej_cnt",   64'(count_o), 64'd7);
    check("rej_tid",   64'(issue_trans_id_o), 64'd0);
    check("rej_ready", 64'(issue_ready_o), 64'd1);
    check("rej_p0_pc", 64'(commit_instr_o[0].pc), 64'h204);
    tick();
    issue_valid_i = 1'b0;
    check("wrap_cnt",   64'(count_o), 64'd8);
    check("wrap_tid",   64'(issue_trans_id_o), 64'd1);
    check("wrap_ready", 64'(issue_ready_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_queue_feeder.md
Name: commit_queue_feeder

Overview:
- Producer end of the commit-stage interface. It drives the per-port scoreboard entry array into the commit stage's instruction inputs and consumes that stage's per-port acknowledge vector.
- Internally it is an in-order circular retire queue. Instructions are allocated at issue, marked finished on writeback, and presented oldest-first on NR_COMMIT_PORTS ports. They are popped when the commit stage acknowledges them.
- It sits between the issue/execute stages and the commit stage. It also serves as a standalone stimulus source for commit-stage timing benches.

Parameters:
- NR_ENTRIES, 8, queue depth; must be a power of two, at least 2.
- NR_COMMIT_PORTS, 2, number of commit ports presented; must be 1 or 2, and at most NR_ENTRIES.
- TRANS_ID_BITS, $clog2(NR_ENTRIES), width of the entry index, which is used as trans_id.
- XLEN, 32, result width.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries (mispredict/exception flush)
- issue_valid_i  in  1  new instruction offered
- issue_instr_i  in  scoreboard_entry_t  decoded instruction; its valid, result and ex fields are ignored
- issue_ready_o  out  1  queue can accept this cycle
- issue_trans_id_o  out  TRANS_ID_BITS  index the instruction will occupy (the current tail)
- wb_valid_i  in  1  functional-unit writeback strobe
- wb_trans_id_i  in  TRANS_ID_BITS  target entry
- wb_result_i  in  XLEN  result value
- wb_ex_i  in  exception_t  exception raised by the functional unit
- commit_instr_o  out  [NR_COMMIT_PORTS] scoreboard_entry_t  oldest entries; port k holds entry head+k
- commit_ack_i  in  NR_COMMIT_PORTS  per-port retire acknowledge
- count_o  out  TRANS_ID_BITS+1  number of occupied entries

Behaviour:
- Reset (asynchronous, rst_ni low):
  - head = 0, tail = 0, count = 0.
  - All entry allocated/finished flags = 0.
  - Outputs: issue_ready_o = 1, issue_trans_id_o = 0, count_o = 0, every commit_instr_o[k].valid = 0.
  - Entry payload storage is not reset.
- Storage: per entry, a registered scoreboard_entry_t plus allocated and finished flags.
- Issue:
  - issue_ready_o = (count < NR_ENTRIES), combinational from registered count only.
  - On issue_valid_i && issue_ready_o at a clock edge:
    - entry[tail] = issue_instr_i with result = 0, ex.valid = 0, finished = 0, allocated = 1.
    - tail advances modulo NR_ENTRIES.
  - issue_trans_id_o = tail at all times.
- Writeback:
  - On wb_valid_i with entry[wb_trans_id_i].allocated = 1 at a clock edge:
    - result = wb_result_i, ex = wb_ex_i, finished = 1.
  - Writeback to an unallocated entry is ignored; simulation-only assertion error.
- Commit presentation (combinational from registers):
  - commit_instr_o[k] = entry[(head+k) mod NR_ENTRIES].
  - .valid = (k < count) && finished of that entry.
  - Minimum latency: writeback edge to presented valid is 1 cycle. There is no same-cycle bypass.
- Ack:
  - pop = commit_ack_i[0] + (commit_ack_i[0] & commit_ack_i[1]).
  - Ack on port 1 without port 0 is illegal: it is ignored and flagged by an assertion.
  - Ack on a port whose presented valid = 0 is ignored and flagged by an assertion.
  - Popped entries clear allocated/finished; head += pop, modulo NR_ENTRIES.
- Simultaneous events:
  - Issue and pop in the same cycle: count += push − pop.
  - Issue is still gated by the pre-pop count, so a full queue rejects issue even while popping.
  - Writeback to an entry being popped in the same cycle cannot occur: the popped entry is already finished. A second writeback to a finished entry overwrites it, and an assertion warns.
- Flush:
  - Synchronous; highest priority. In the flushed cycle, issue, writeback and ack have no effect.
  - head = tail = 0, count = 0, all flags cleared.
  - Next cycle: all commit valids = 0 and issue_ready_o = 1.
- Wrap-around:
  - Pointers are TRANS_ID_BITS wide and wrap naturally.
  - Full/empty are distinguished by count, never by pointer equality.

Decomposition:
- Shared package commit_feeder_pkg holds:
  - the local entry-flag struct (allocated, finished);
  - default parameters;
  - a helper function for modulo pointer add.
- scoreboard_entry_t, exception_t and fu_op are reused from the existing CVA6 package, not redefined.
- Natural sub-module: commit_feeder_ptr_ctrl. It holds the head/tail/count registers and computes push/pop/flush. The entry array and the output muxing stay in the top module.

Test Plan:
- Reset then idle -> issue_ready_o = 1, issue_trans_id_o = 0, count_o = 0, commit_instr_o[0].valid = 0 and [1].valid = 0.
- Issue 3 instructions (pc 0x100, 0x104, 0x108), writeback id 1 then id 0 with result 0xAA, 0xBB -> one cycle after the id 0 writeback, ports 0/1 show pc 0x100/0x104 both valid. Ack both -> count_o = 1, port 0 shows pc 0x108 with valid = 0.
- Fill 8 entries -> issue_ready_o = 0. Ack 1 while offering an issue -> issue rejected, count_o = 7. Next cycle issue accepted with issue_trans_id_o = 0 (wrap).
- Writeback with wb_ex_i.valid = 1, cause 2, to the head entry -> port 0 valid with ex.valid = 1, cause 2. Commit-stage ack port 0 -> entry popped.
- Flush_i asserted in the same cycle as an issue, a writeback and an ack with 5 entries occupied -> next cycle count_o = 0, issue_trans_id_o = 0, all commit valids = 0.
- Ack on port 1 only, and ack on an unfinished head entry -> no state change, assertion fires in both cases.
